// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: byte-wide register writes, one shared prescaled 8-bit period counter.
// Optional `PWM_SHADOW_EN`: duty cycles are double-buffered and reload on the 255->0 counter wrap.

module pwm_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_out_i,
  input  logic       we_pwm_i,
  input  logic       we_duty_i,
  input  logic       bit_i,
  input  logic [7:0] duty_i,
  input  logic [7:0] cnt_i,
  input  logic       wrap_i,
  output logic       pwm_o
);
  logic       en_out_q, en_pwm_q, pwm_q, pwm_d, lvl;
  logic [7:0] duty_act_q;
`ifdef PWM_SHADOW_EN
  logic [7:0] duty_shd_q;
`endif

  // 0xFF is treated as fully on rather than 255/256.
  assign lvl   = (duty_act_q == 8'hFF) ? 1'b1 : (cnt_i < duty_act_q);
  assign pwm_d = en_out_q & (en_pwm_q ? lvl : 1'b1);
  assign pwm_o = pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q   <= 1'b0;
      en_pwm_q   <= 1'b0;
      duty_act_q <= 8'h00;
`ifdef PWM_SHADOW_EN
      duty_shd_q <= 8'h00;
`endif
      pwm_q      <= 1'b0;
    end else begin
      if (we_out_i) en_out_q <= bit_i;
      if (we_pwm_i) en_pwm_q <= bit_i;
`ifdef PWM_SHADOW_EN
      // A write on the wrap edge lands in the shadow only; active takes the old shadow.
      if (we_duty_i) duty_shd_q <= duty_i;
      if (wrap_i)    duty_act_q <= duty_shd_q;
`else
      if (we_duty_i) duty_act_q <= duty_i;
`endif
      pwm_q <= pwm_d;
    end
  end

`ifndef PWM_SHADOW_EN
  logic unused_wrap;
  assign unused_wrap = wrap_i;
`endif
endmodule

module pwm_bank #(
  parameter int NUM_CH    = 16,
  parameter int PRESC_DIV = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          period_start_q, tick, wrap;

  assign tick         = (presc_q == PW'(PRESC_DIV - 1));
  assign wrap         = tick && (cnt_q == 8'hFF);
  assign presc_d      = tick ? '0 : presc_q + 1'b1;
  assign cnt_d        = tick ? cnt_q + 8'd1 : cnt_q;
  assign period_start = period_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= 8'h00;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= wrap;
    end
  end

  // Channels that do not exist have no decode, so their writes fall on the floor.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic we_out, we_pwm, we_duty;
    assign we_out  = wr_valid && (wr_addr == 8'(i / 8));
    assign we_pwm  = wr_valid && (wr_addr == 8'(4 + i / 8));
    assign we_duty = wr_valid && (wr_addr == 8'(16 + i));

    pwm_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_out_i (we_out),
      .we_pwm_i (we_pwm),
      .we_duty_i(we_duty),
      .bit_i    (wr_data[i % 8]),
      .duty_i   (wr_data),
      .cnt_i    (cnt_q),
      .wrap_i   (wrap),
      .pwm_o    (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: main instance (16 ch, PRESC_DIV=1) plus a 4-ch PRESC_DIV=3 instance.
// Expectations follow `PWM_SHADOW_EN` when the macro is defined for the build.

module tb_pwm_bank;
`ifdef PWM_SHADOW_EN
  localparam bit SHD = 1'b1;
`else
  localparam bit SHD = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
  logic [7:0]  wr_addr = 8'h00, wr_data = 8'h00;
  logic [15:0] pwm_out;
  logic        period_start;
  logic [3:0]  pwm2;
  logic        ps2;
  int          checks = 0, errors = 0;
  int          ecnt;

  always #5 clk = ~clk;

  // Edges since reset release; with PRESC_DIV=1 this mod 256 equals the DUT counter.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  pwm_bank #(.NUM_CH(16), .PRESC_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_bank #(.NUM_CH(4), .PRESC_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .pwm_out(pwm2), .period_start(ps2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic sync(input int ph);
    for (int n = 0; n < 600 && (ecnt % 256) != ph; n++) step();
    chk("sync", 32'(ecnt % 256), 32'(ph));
  endtask

  // n samples of channel b; checks period_start phase and, if duty >= 0, the exact waveform.
  task automatic period(input int b, input int n, input int duty, output int hi, output int bad);
    hi  = 0;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      step();
      hi += int'(pwm_out[b]);
      if (period_start !== ((ecnt % 256) == 0)) bad++;
      if (duty >= 0 && pwm_out[b] !== ((duty == 255) || (((ecnt + 255) % 256) < duty))) bad++;
    end
  endtask

  initial begin
    int hi, bad, hi2, bad2;
    repeat (3) step();
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_pwm2", 32'(pwm2), 0);
    rst_n = 1'b1;

    wr(8'h00, 8'h01);
    chk("en_latency", 32'(pwm_out), 0);
    step();
    chk("en_out0", 32'(pwm_out), 32'h0001);

    // Channel 3 PWM at 0x40, channel 0 steady on.
    wr(8'h13, 8'h40);
    wr(8'h04, 8'h08);
    wr(8'h00, 8'h09);
    sync(0);
    period(3, 256, 8'h40, hi, bad);
    chk("duty40_hi", 32'(hi), 64);
    chk("duty40_phase", 32'(bad), 0);
    chk("ch0_steady", 32'(pwm_out[0]), 1);

    // Prescaled instance: 768-cycle period, 192 high cycles at duty 0x40.
    repeat (1536) step();
    hi2 = 0;
    bad2 = 0;
    for (int k = 0; k < 768; k++) begin
      step();
      hi2 += int'(pwm2[3]);
      if (ps2 !== ((ecnt % 768) == 0)) bad2++;
    end
    chk("presc3_hi", 32'(hi2), 192);
    chk("presc3_ps", 32'(bad2), 0);

    // Duty extremes.
    wr(8'h11, 8'h00);
    wr(8'h12, 8'hFF);
    wr(8'h04, 8'h0E);
    wr(8'h00, 8'h0F);
    sync(0);
    period(1, 256, 0, hi, bad);
    chk("duty00_hi", 32'(hi), 0);
    chk("duty00_phase", 32'(bad), 0);
    period(2, 256, 255, hi, bad);
    chk("dutyFF_hi", 32'(hi), 256);
    chk("dutyFF_phase", 32'(bad), 0);

    // Mid-period duty change at cnt=100.
    sync(99);
    wr(8'h13, 8'hC0);
    chk("mid_before", 32'(pwm_out[3]), 0);
    step();
    chk("mid_after", 32'(pwm_out[3]), SHD ? 0 : 1);
    sync(0);
    period(3, 256, 8'hC0, hi, bad);
    chk("mid_next_hi", 32'(hi), 192);
    chk("mid_next_phase", 32'(bad), 0);

    // Duty write coincident with the wrap edge.
    sync(50);
    wr(8'h13, 8'h40);
    sync(0);
    sync(255);
    wr(8'h13, 8'hC0);
    chk("wrap_edge_ph", 32'(ecnt % 256), 0);
    period(3, 256, -1, hi, bad);
    chk("wrap_p1_hi", 32'(hi), SHD ? 64 : 192);
    chk("wrap_p1_ps", 32'(bad), 0);
    period(3, 256, 8'hC0, hi, bad);
    chk("wrap_p2_hi", 32'(hi), 192);

    // Unmapped addresses must not disturb anything.
    wr(8'h00, 8'h08);
    wr(8'h04, 8'h08);
    wr(8'h20, 8'hFF);
    wr(8'h08, 8'hFF);
    wr(8'hFF, 8'hFF);
    wr(8'h06, 8'hFF);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if ((pwm_out & 16'hFFF7) != 16'h0000) bad++;
    end
    chk("ignored_others", 32'(bad), 0);
    sync(0);
    period(3, 256, 8'hC0, hi, bad);
    chk("ignored_ch3_hi", 32'(hi), 192);
    chk("ignored_ch3_phase", 32'(bad), 0);

    // Reset mid-period.
    sync(128);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 0);
    chk("async_rst_ps", 32'(period_start), 0);
    chk("async_rst_pwm2", 32'(pwm2), 0);
    step();
    rst_n = 1'b1;
    wr(8'h04, 8'h08);
    wr(8'h00, 8'h09);
    step();
    chk("post_rst_en", 32'(pwm_out), 32'h0001);
    period(3, 300, 0, hi, bad);
    chk("post_rst_duty0", 32'(hi), 0);
    chk("post_rst_phase", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
